// File: rtl/toggle_strobe_array.sv
// Multi-channel toggle-to-strobe converter with synchronisers, priming, and sticky pending/overrun flags.
// Optional saturating per-channel event counters are built when TOGGLE_STROBE_ARRAY_COUNT_EN is defined.
module toggle_strobe_array #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS-1:0]       i_toggle,
    input  logic [2*CHANNELS-1:0]     i_mode,
    input  logic [CHANNELS-1:0]       i_ack,
    input  logic                      i_cnt_clr,
    output logic [CHANNELS-1:0]       o_strobe,
    output logic [CHANNELS-1:0]       o_pending,
    output logic [CHANNELS-1:0]       o_overrun,
    output logic [CNT_W*CHANNELS-1:0] o_count
);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_r;
    logic [CHANNELS-1:0] last_r;
    logic [2:0]          prime_cnt_r;
    logic                armed_r;
    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] rise_s;
    logic [CHANNELS-1:0] fall_s;
    logic [CHANNELS-1:0] sel_s;
    logic [CHANNELS-1:0] event_s;
    logic [CHANNELS-1:0] pending_nxt_s;
    logic [CHANNELS-1:0] overrun_nxt_s;

    // Synchroniser chain and last-sample register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= '0;
            last_r <= '0;
        end else begin
            sync_r[0] <= i_toggle;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            last_r <= sync_s;
        end
    end

    // Priming: events stay masked until the chain and last-sample hold post-reset data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prime_cnt_r <= 3'd0;
            armed_r     <= 1'b0;
        end else if (!armed_r) begin
            if (prime_cnt_r == 3'(SYNC_STAGES)) begin
                armed_r <= 1'b1;
            end else begin
                prime_cnt_r <= prime_cnt_r + 3'd1;
            end
        end else begin
            armed_r <= 1'b1;
        end
    end

    // Edge detection, mode selection and pending/overrun next-state.
    always_comb begin
        sync_s        = sync_r[SYNC_STAGES-1];
        rise_s        = sync_s & ~last_r;
        fall_s        = ~sync_s & last_r;
        sel_s         = '0;
        pending_nxt_s = o_pending;
        overrun_nxt_s = o_overrun;
        for (int n = 0; n < CHANNELS; n++) begin
            case (i_mode[2*n +: 2])
                2'b00:   sel_s[n] = rise_s[n] | fall_s[n];
                2'b01:   sel_s[n] = rise_s[n];
                2'b10:   sel_s[n] = fall_s[n];
                default: sel_s[n] = 1'b0;
            endcase
        end
        event_s = sel_s & {CHANNELS{armed_r}};
        for (int n = 0; n < CHANNELS; n++) begin
            // An ack coincident with a new event keeps the new event pending.
            if (i_ack[n]) begin
                if (event_s[n]) begin
                    pending_nxt_s[n] = 1'b1;
                end else begin
                    pending_nxt_s[n] = 1'b0;
                    overrun_nxt_s[n] = 1'b0;
                end
            end else if (event_s[n]) begin
                if (o_pending[n]) begin
                    overrun_nxt_s[n] = 1'b1;
                end else begin
                    overrun_nxt_s[n] = o_overrun[n];
                end
                pending_nxt_s[n] = 1'b1;
            end else begin
                pending_nxt_s[n] = o_pending[n];
            end
        end
    end

    // Registered strobe and sticky flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_strobe  <= '0;
            o_pending <= '0;
            o_overrun <= '0;
        end else begin
            o_strobe  <= event_s;
            o_pending <= pending_nxt_s;
            o_overrun <= overrun_nxt_s;
        end
    end

`ifdef TOGGLE_STROBE_ARRAY_COUNT_EN
    logic [CHANNELS-1:0][CNT_W-1:0] count_r;

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= '0;
        end else if (i_cnt_clr) begin
            count_r <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (event_s[n] && (count_r[n] != {CNT_W{1'b1}})) begin
                    count_r[n] <= count_r[n] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign o_count = count_r;
`else
    logic cnt_clr_unused_s;
    assign cnt_clr_unused_s = i_cnt_clr;
    assign o_count          = '0;
`endif

endmodule

// File: tb/tb_toggle_strobe_array.sv
// Directed self-checking bench for toggle_strobe_array (8 channels, 2 sync stages, 4-bit counters).
module tb_toggle_strobe_array;

    localparam int CH = 8;
    localparam int CW = 4;

    logic              clk;
    logic              rst_n;
    logic [CH-1:0]     toggle;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     ack;
    logic              cnt_clr;
    logic [CH-1:0]     strobe;
    logic [CH-1:0]     pending;
    logic [CH-1:0]     overrun;
    logic [CW*CH-1:0]  count;

    int passed = 0;
    int total  = 0;

    toggle_strobe_array #(.CHANNELS(CH), .SYNC_STAGES(2), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_toggle(toggle), .i_mode(mode),
        .i_ack(ack), .i_cnt_clr(cnt_clr), .o_strobe(strobe),
        .o_pending(pending), .o_overrun(overrun), .o_count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        toggle  = 8'hFF;
        mode    = 16'h0000;
        ack     = 8'h00;
        cnt_clr = 1'b0;
        #23;
        check("reset_strobe", 64'(strobe), 64'h0);
        check("reset_pending", 64'(pending), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Inputs held high through reset must not strobe.
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("prime_no_strobe", 64'(strobe), 64'h0);
        end
        check("prime_pending", 64'(pending), 64'h0);

        // Bring inputs low with all channels disabled, then enable mode 00.
        mode = 16'hFFFF;
        toggle = 8'h00;
        step(5);
        check("disabled_no_pending", 64'(pending), 64'h0);
        mode = 16'h0000;
        step(1);
        check("mode_change_no_strobe", 64'(strobe), 64'h0);

        // Channel 0, both edges.
        toggle[0] = 1'b1;
        step(2);
        check("ch0_rise_early", 64'(strobe), 64'h0);
        step(1);
        check("ch0_rise_strobe", 64'(strobe), 64'h01);
        check("ch0_pending", 64'(pending), 64'h01);
        step(1);
        check("ch0_rise_one_cycle", 64'(strobe), 64'h0);
        step(6);
        toggle[0] = 1'b0;
        step(3);
        check("ch0_fall_strobe", 64'(strobe), 64'h01);
        step(1);
        check("ch0_fall_one_cycle", 64'(strobe), 64'h0);

        // ch1 rising, ch2 falling, ch3 disabled.
        mode[3:2] = 2'b01;
        mode[5:4] = 2'b10;
        mode[7:6] = 2'b11;
        step(1);
        toggle[3:1] = 3'b111;
        step(3);
        check("modes_rise", 64'(strobe), 64'h02);
        step(3);
        toggle[3:1] = 3'b000;
        step(3);
        check("modes_fall", 64'(strobe), 64'h04);
        step(1);
        check("modes_pending", 64'(pending), 64'h07);
        check("ch0_overrun", 64'(overrun), 64'h01);
        ack = 8'hFF;
        step(1);
        ack = 8'h00;
        check("ack_all_pending", 64'(pending), 64'h0);
        check("ack_all_overrun", 64'(overrun), 64'h0);

        // Channel 4 overrun and ack behaviour.
        toggle[4] = 1'b1;
        step(4);
        toggle[4] = 1'b0;
        step(4);
        check("ch4_overrun", 64'(overrun), 64'h10);
        check("ch4_pending", 64'(pending), 64'h10);
        ack[4] = 1'b1;
        step(1);
        ack[4] = 1'b0;
        check("ch4_ack_pending", 64'(pending), 64'h0);
        check("ch4_ack_overrun", 64'(overrun), 64'h0);
        toggle[4] = 1'b1;
        step(2);
        ack[4] = 1'b1;
        step(1);
        ack[4] = 1'b0;
        check("ch4_evt_ack_strobe", 64'(strobe), 64'h10);
        check("ch4_evt_ack_pending", 64'(pending), 64'h10);
        check("ch4_evt_ack_overrun", 64'(overrun), 64'h0);
        step(2);
        toggle[4] = 1'b0;
        step(4);
        check("ch4_second_overrun", 64'(overrun), 64'h10);
        toggle[4] = 1'b1;
        step(2);
        ack[4] = 1'b1;
        step(1);
        ack[4] = 1'b0;
        check("ch4_ack_keeps_overrun", 64'(overrun), 64'h10);
        check("ch4_ack_keeps_pending", 64'(pending), 64'h10);
        ack[4] = 1'b1;
        step(1);
        ack[4] = 1'b0;
        check("ch4_final_clear", 64'({pending[4], overrun[4]}), 64'h0);

        // Back-to-back changes on channel 6.
        toggle[6] = 1'b1;
        step(1);
        toggle[6] = 1'b0;
        step(2);
        check("b2b_first", 64'(strobe), 64'h40);
        step(1);
        check("b2b_second", 64'(strobe), 64'h40);
        step(1);
        check("b2b_end", 64'(strobe), 64'h0);

`ifdef TOGGLE_STROBE_ARRAY_COUNT_EN
        for (int i = 0; i < 20; i++) begin
            toggle[5] = ~toggle[5];
            step(2);
        end
        step(3);
        check("ch5_count_sat", 64'(count[23:20]), 64'hF);
        check("ch0_count", 64'(count[3:0]), 64'h2);
        toggle[5] = ~toggle[5];
        step(2);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        check("clr_evt_strobe", 64'(strobe), 64'h20);
        check("clr_evt_count", 64'(count), 64'h0);
        toggle[5] = ~toggle[5];
        step(3);
        check("count_after_clr", 64'(count[23:20]), 64'h1);
`else
        toggle[5] = 1'b1;
        step(3);
        check("nocount_strobe", 64'(strobe), 64'h20);
        check("nocount_zero", 64'(count), 64'h0);
`endif

        // Asynchronous reset while a strobe is active.
        toggle[7] = 1'b1;
        step(3);
        check("pre_reset_strobe", 64'(strobe), 64'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_strobe", 64'(strobe), 64'h0);
        check("async_pending", 64'(pending), 64'h0);
        check("async_overrun", 64'(overrun), 64'h0);
        check("async_count", 64'(count), 64'h0);
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("reprime_no_strobe", 64'(strobe), 64'h0);
        end
        toggle[7] = 1'b0;
        step(3);
        check("rearmed_strobe", 64'(strobe), 64'h80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/toggle_strobe_array.md
# toggle_strobe_array

Multi-channel, parametrised successor to the single-bit toggle-to-strobe converter. Each channel synchronises an asynchronous level/toggle input into the `i_clk` domain and emits a one-cycle strobe on the edge type selected per channel (both, rising, falling or disabled). Each channel also keeps a sticky pending/overrun record that software or downstream logic clears with a per-channel acknowledge. Two things are removed by design: the spurious strobe when leaving reset, and the metastability exposure. The block sits between GPIO/FPGA-fabric handshake toggles and the register/interrupt logic.

## Interface
Parameters:
- `CHANNELS`, 8: number of independent channels (1–32).
- `SYNC_STAGES`, 2: synchroniser flops per channel (2–4).
- `CNT_W`, 8: width of each per-channel event counter (used only with the counter feature).

Ports:
- `i_clk`  in  1: sole clock.
- `i_rst_n`  in  1: reset, asynchronous assert, active-low.
- `i_toggle`  in  CHANNELS: asynchronous channel inputs.
- `i_mode`  in  2*CHANNELS: per-channel edge select, bits [2n+1:2n]. 00 = both edges, 01 = rising, 10 = falling, 11 = disabled.
- `i_ack`  in  CHANNELS: per-channel clear of pending/overrun.
- `i_cnt_clr`  in  1: clears all event counters.
- `o_strobe`  out  CHANNELS: one-cycle event pulse per channel.
- `o_pending`  out  CHANNELS: sticky "event seen since last ack".
- `o_overrun`  out  CHANNELS: sticky "event seen while already pending".
- `o_count`  out  CNT_W*CHANNELS: per-channel saturating event counts, bits [CNT_W*(n+1)-1:CNT_W*n].

## Operation
- Reset (`i_rst_n` = 0, asynchronous) clears every register to 0: synchronisers, last-sample, prime counter, armed flag, `o_strobe`, `o_pending`, `o_overrun`, `o_count`.
- **Priming:**
  - After reset release, a shared prime counter runs for SYNC_STAGES+1 cycles.
  - During priming, last-sample loads from the synchroniser output and all strobes are suppressed.
  - `armed` then goes to 1 and stays at 1 until the next reset.
  - A channel input held at 1 through reset therefore produces no strobe.
- **Detect:** for a synchronised value `s` and last sample `l`:
  - rise = `s & ~l`; fall = `~s & l`.
  - The event is selected by the channel's `i_mode`.
  - `o_strobe[n]` <= `armed & event`.
  - Last-sample updates every cycle regardless of mode.
  - A mode change takes effect on the next edge and never generates an event by itself.
- **Pending/overrun**, per channel, evaluated each edge:
  - `i_ack` = 1 and event = 1: pending = 1, overrun unchanged. The ack consumes the old event and the new one is kept.
  - `i_ack` = 1, no event: pending = 0, overrun = 0.
  - `i_ack` = 0, event, pending already 1: overrun = 1.
  - `i_ack` = 0, event: pending = 1.
- Channels are fully independent. Simultaneous events on any set of channels are all reported in the same cycle.
- Pulses on `i_toggle` shorter than one `i_clk` period may be missed; this is accepted behaviour and is not reported.

## Timing
- Let edge E0 be the first edge that samples a new `i_toggle` value meeting setup.
  - The synchroniser output changes at edge E(SYNC_STAGES−1).
  - `o_strobe` is high for exactly the one cycle following edge E(SYNC_STAGES).
  - Default latency is therefore 3 edges.
- `o_pending`, `o_overrun` and `o_count` update on the same edge that asserts `o_strobe`.
- `i_ack` and `i_cnt_clr` are synchronous and single-cycle effective. Holding them high keeps the state clear, except for the event-wins rule above.
- Back-to-back input changes one cycle apart yield back-to-back strobes (for mode 00).
- Reset asserted mid-operation clears all state immediately. Priming restarts on release.

## Configuration
- Macro `TOGGLE_STROBE_ARRAY_COUNT_EN`.
- **Defined:**
  - Each channel has a CNT_W-bit counter that increments on every edge where `o_strobe[n]` is asserted.
  - The counter saturates at all-ones and does not wrap.
  - `i_cnt_clr` forces all counters to 0 and takes priority over a same-cycle increment (result 0).
- **Not defined:**
  - No counter registers are built.
  - `o_count` is tied to 0 and `i_cnt_clr` is ignored.
  - The port list is unchanged.

## Test plan
- Hold `i_toggle` = 8'hFF through reset, release, wait 10 cycles -> `o_strobe` stays 0; `o_pending` = 0.
- Channel 0, mode 00: toggle 0→1 then 1→0 ten cycles later -> two one-cycle strobes, each high in the cycle after the 3rd edge after the change; `o_pending[0]` = 1.
- Channel 1 in mode 01, channel 2 in mode 10, channel 3 in mode 11; drive a full pulse on each -> strobe on ch1 at the rise only, ch2 at the fall only, ch3 none.
- Two events on channel 4 with no ack -> `o_overrun[4]` = 1. Pulse `i_ack[4]` -> both pending and overrun are 0. Event coincident with ack -> pending = 1, overrun = 0.
- With `TOGGLE_STROBE_ARRAY_COUNT_EN` and CNT_W = 4: 20 events on channel 5 -> `o_count` channel 5 = 4'hF. Assert `i_cnt_clr` in the same cycle as an event -> count 0.
- Assert `i_rst_n` = 0 asynchronously while strobes and pending flags are active -> all outputs go to 0 at once, without waiting for a clock edge.
